// File: rtl/serial_loop_fifo_if.sv
// Byte-stream bundle between the UART receive/transmit side and the loopback FIFO,
// including mode control and the status outputs shown on LEDs.
interface serial_loop_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          rx_data;
    logic                new_rx_data;
    logic [7:0]          tx_data;
    logic                new_tx_data;
    logic                tx_busy;
    logic [1:0]          mode;
    logic                clear_overflow;
    logic [DEPTH_LOG2:0] count;
    logic                full;
    logic                empty;
    logic                overflow;

    modport master (
        output rx_data, new_rx_data, tx_busy, mode, clear_overflow,
        input  tx_data, new_tx_data, count, full, empty, overflow
    );

    modport slave (
        input  rx_data, new_rx_data, tx_busy, mode, clear_overflow,
        output tx_data, new_tx_data, count, full, empty, overflow
    );
endinterface

// File: rtl/serial_loop_fifo.sv
// Buffered serial loopback: received bytes are queued and echoed to the transmitter
// in raw, uppercase, line-buffered or flush mode, with sticky overflow reporting.
module serial_loop_fifo #(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] EOL_CHAR   = 8'h0D
) (
    input logic               clk,
    input logic               rst_n,
    serial_loop_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, HOLD} state_t;

    logic [7:0]            mem [DEPTH];
    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d, eol_cnt_q, eol_cnt_d;
    logic                  full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  new_tx_data_q, new_tx_data_d;
    logic [7:0]            head;
    logic                  wr_en, drop, pop, eligible, wr_eol, pop_eol;

    function automatic logic [7:0] xform(input logic [7:0] b, input logic [1:0] m);
        if (m == 2'd1 && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

    always_comb begin
        head     = mem[rd_ptr_q];
        // Full/empty come from registered state, so a pop in the same cycle never frees a slot early.
        wr_en    = bus.new_rx_data && bus.mode != 2'd3 && !full_q;
        drop     = bus.new_rx_data && bus.mode != 2'd3 && full_q;
        eligible = !empty_q && (bus.mode != 2'd2 || eol_cnt_q != '0 || full_q);

        state_d       = state_q;
        pop           = 1'b0;
        tx_data_d     = tx_data_q;
        new_tx_data_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mode == 2'd3) begin
                    pop = !empty_q;
                end else if (eligible && !bus.tx_busy) begin
                    pop           = 1'b1;
                    tx_data_d     = xform(head, bus.mode);
                    new_tx_data_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);

        wr_eol  = wr_en && bus.rx_data == EOL_CHAR;
        pop_eol = pop && head == EOL_CHAR;
        eol_cnt_d = eol_cnt_q;
        if (wr_eol && !pop_eol)      eol_cnt_d = eol_cnt_q + CNT_ONE;
        else if (!wr_eol && pop_eol) eol_cnt_d = eol_cnt_q - CNT_ONE;

        if (drop)                    overflow_d = 1'b1;
        else if (bus.clear_overflow) overflow_d = 1'b0;
        else                         overflow_d = overflow_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            eol_cnt_q     <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            overflow_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            new_tx_data_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            eol_cnt_q     <= eol_cnt_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            overflow_q    <= overflow_d;
            tx_data_q     <= tx_data_d;
            new_tx_data_q <= new_tx_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= bus.rx_data;
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.new_tx_data = new_tx_data_q;
    assign bus.count       = count_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_serial_loop_fifo.sv
// Bench for serial_loop_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_serial_loop_fifo;
    localparam int         DL    = 4;
    localparam int         DEPTH = 16;
    localparam logic [7:0] EOL   = 8'h0D;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_loop_fifo_if #(.DEPTH_LOG2(DL)) bus ();
    serial_loop_fifo #(.DEPTH_LOG2(DL), .EOL_CHAR(EOL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] upper(input logic [7:0] b, input logic [1:0] m);
        if (m == 2'd1 && b >= "a" && b <= "z") return b - 8'd32;
        return b;
    endfunction

    // Reference model: the FIFO is a queue; after each strobe one edge is skipped.
    logic [7:0] q[$];
    logic [7:0] sent[$];
    int         sent_cyc[$];
    logic [7:0] m_tx;
    logic       m_strb, m_ovf;
    bit         model_on = 0;
    int         cyc = 0;

    always @(posedge clk) begin : model
        int n;
        int eols;
        bit stb;
        bit dropped;
        cyc++;
        if (!rst_n) begin
            q.delete();
            m_tx = 8'h00; m_strb = 1'b0; m_ovf = 1'b0;
            model_on = 1;
        end else if (model_on) begin
            n = q.size();
            eols = 0;
            foreach (q[i]) if (q[i] == EOL) eols++;
            stb = 0;
            if (!m_strb) begin
                if (bus.mode == 2'd3) begin
                    if (n > 0) q.delete(0);
                end else if (n > 0 && !bus.tx_busy &&
                             (bus.mode != 2'd2 || eols > 0 || n == DEPTH)) begin
                    m_tx = upper(q[0], bus.mode);
                    q.delete(0);
                    stb = 1;
                end
            end
            dropped = bus.new_rx_data && bus.mode != 2'd3 && n == DEPTH;
            if (bus.new_rx_data && bus.mode != 2'd3 && n < DEPTH) q.push_back(bus.rx_data);
            if (dropped) m_ovf = 1'b1;
            else if (bus.clear_overflow) m_ovf = 1'b0;
            m_strb = stb;
        end
        #1;
        if (model_on) begin
            check("m_new_tx", bus.new_tx_data, m_strb);
            check("m_tx_data", bus.tx_data, m_tx);
            check("m_count", bus.count, q.size());
            check("m_full", bus.full, q.size() == DEPTH);
            check("m_empty", bus.empty, q.size() == 0);
            check("m_overflow", bus.overflow, m_ovf);
            if (bus.new_tx_data === 1'b1) begin
                sent.push_back(bus.tx_data);
                sent_cyc.push_back(cyc);
            end
        end
    end

    function automatic logic [7:0] sent_at(input int i);
        if (i < sent.size()) return sent[i];
        return 8'hxx;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.new_rx_data = 1'b1;
        bus.rx_data     = b;
        @(negedge clk);
        bus.new_rx_data = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp1 [4];
        bit         seen;
        rst_n = 1'b0;
        bus.rx_data = 8'h00; bus.new_rx_data = 1'b0; bus.tx_busy = 1'b0;
        bus.mode = 2'd0; bus.clear_overflow = 1'b0;
        idle(3);
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_strobe", bus.new_tx_data, 0);
        check("rst_txdata", bus.tx_data, 8'h00);
        rst_n = 1'b1;
        idle(2);

        // Raw echo
        sent.delete(); sent_cyc.delete();
        send(8'h41); send(8'h42);
        idle(10);
        check("raw_n", sent.size(), 2);
        check("raw_0", sent_at(0), 8'h41);
        check("raw_1", sent_at(1), 8'h42);
        if (sent_cyc.size() == 2) check("raw_gap", (sent_cyc[1] - sent_cyc[0]) >= 2, 1);
        check("raw_count", bus.count, 0);
        check("raw_empty", bus.empty, 1);

        // Uppercase echo
        bus.mode = 2'd1;
        sent.delete();
        exp1[0] = 8'h41; exp1[1] = 8'h5A; exp1[2] = 8'h5B; exp1[3] = 8'h31;
        send(8'h61); send(8'h7A); send(8'h5B); send(8'h31);
        idle(15);
        check("up_n", sent.size(), 4);
        for (int i = 0; i < 4; i++) check("up_byte", sent_at(i), exp1[i]);

        // Line mode
        bus.mode = 2'd2;
        sent.delete();
        send(8'h68); send(8'h69);
        idle(20);
        check("line_hold_n", sent.size(), 0);
        check("line_hold_cnt", bus.count, 2);
        send(8'h0D);
        idle(10);
        check("line_n", sent.size(), 3);
        check("line_0", sent_at(0), 8'h68);
        check("line_1", sent_at(1), 8'h69);
        check("line_2", sent_at(2), 8'h0D);
        check("line_eol", dut.eol_cnt_q, 0);

        // Backpressure and overflow
        bus.mode = 2'd0;
        bus.tx_busy = 1'b1;
        sent.delete();
        for (int i = 0; i < 17; i++) send(8'h10 + 8'(i));
        check("bp_full", bus.full, 1);
        check("bp_count", bus.count, 16);
        check("bp_ovf", bus.overflow, 1);
        @(negedge clk) bus.clear_overflow = 1'b1;
        @(negedge clk) bus.clear_overflow = 1'b0;
        check("bp_clr", bus.overflow, 0);
        bus.tx_busy = 1'b0;
        idle(40);
        check("bp_n", sent.size(), 16);
        for (int i = 0; i < 16; i++) check("bp_byte", sent_at(i), 8'h10 + 8'(i));

        // Write on full FIFO coinciding with pop, then with clear_overflow
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) send(8'h80 + 8'(i));
        check("sim_ovf0", bus.overflow, 0);
        @(negedge clk);
        bus.tx_busy = 1'b0; bus.new_rx_data = 1'b1; bus.rx_data = 8'hEE;
        @(negedge clk);
        bus.tx_busy = 1'b1; bus.new_rx_data = 1'b0;
        check("sim_pop_cnt", bus.count, 15);
        check("sim_pop_ovf", bus.overflow, 1);
        @(negedge clk) bus.clear_overflow = 1'b1;
        @(negedge clk) bus.clear_overflow = 1'b0;
        send(8'h99);
        check("sim_refull", bus.count, 16);
        @(negedge clk);
        bus.new_rx_data = 1'b1; bus.rx_data = 8'hEF; bus.clear_overflow = 1'b1;
        @(negedge clk);
        bus.new_rx_data = 1'b0; bus.clear_overflow = 1'b0;
        check("sim_clr_ovf", bus.overflow, 1);
        @(negedge clk) bus.clear_overflow = 1'b1;
        @(negedge clk) bus.clear_overflow = 1'b0;
        bus.tx_busy = 1'b0;
        idle(40);
        check("sim_drain", bus.count, 0);

        // Flush mode
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
        check("fl_start", bus.count, 5);
        @(negedge clk) bus.mode = 2'd3;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #2;
            check("fl_count", bus.count, 5 - i);
            check("fl_nostrb", bus.new_tx_data, 0);
        end
        @(negedge clk);
        bus.mode = 2'd0;

        // Reset while in HOLD
        for (int i = 0; i < 4; i++) send(8'h50 + 8'(i));
        @(negedge clk) bus.tx_busy = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #2;
            if (bus.new_tx_data === 1'b1) seen = 1;
        end
        check("rh_strobe_seen", seen, 1);
        @(negedge clk) rst_n = 1'b0;
        sent.delete();
        @(negedge clk) rst_n = 1'b1;
        check("rh_count", bus.count, 0);
        check("rh_strobe", bus.new_tx_data, 0);
        idle(20);
        check("rh_none", sent.size(), 0);
        check("rh_count2", bus.count, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            @(negedge clk);
            r = int'($urandom_range(0, 3));
            bus.new_rx_data    = ($urandom_range(0, 2) == 0);
            bus.rx_data        = (r == 0) ? EOL : (r == 1) ? 8'h61 + 8'($urandom_range(0, 25))
                                                           : 8'($urandom);
            bus.tx_busy        = ($urandom_range(0, 3) == 0);
            bus.clear_overflow = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) bus.mode = ($urandom_range(0, 7) == 0) ? 2'd3
                                                       : 2'($urandom_range(0, 2));
        end
        @(negedge clk);
        bus.new_rx_data = 1'b0; bus.clear_overflow = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_loop_fifo.md
Name: serial_loop_fifo

Overview:
Buffered, mode-selectable successor to the direct serial loopback. It sits between the AVR interface's receive outputs (rx_data/new_rx_data) and transmit inputs (tx_data/new_tx_data/tx_busy). Received bytes go into a parametrised FIFO and are drained to the transmitter under tx_busy flow control. Modes are raw echo, uppercase echo, line-buffered echo and flush. Overflow and fill status are exported for LEDs and debug.

Parameters:
DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 bytes (valid range 2..8).
EOL_CHAR, 8'h0D, end-of-line byte that releases data in line mode.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  synchronous active-low reset.
rx_data  input  8  received byte; valid only while new_rx_data=1.
new_rx_data  input  1  one-cycle strobe, one byte per strobe.
tx_data  output  8  byte to transmit; valid while new_tx_data=1.
new_tx_data  output  1  one-cycle transmit strobe.
tx_busy  input  1  transmitter busy; no strobe is issued while high.
mode  input  2  0 raw, 1 uppercase, 2 line, 3 flush.
clear_overflow  input  1  clears the sticky overflow flag.
count  output  DEPTH_LOG2+1  current FIFO occupancy.
full  output  1  count == 2**DEPTH_LOG2.
empty  output  1  count == 0.
overflow  output  1  sticky: a byte was dropped.

Behaviour:
- Reset, applied on a clk edge with rst_n=0:
  - tx_data=0, new_tx_data=0, count=0, empty=1, full=0, overflow=0.
  - Pointers, EOL counter and FSM are cleared; FSM goes to IDLE.
  - Reset mid-transmission discards all FIFO contents and any pending strobe.
- Write:
  - A write occurs on new_rx_data=1 with full=0, sampled before the edge, in modes 0–2.
  - In mode 3, incoming bytes are discarded and overflow is not set.
  - If full=1 when new_rx_data=1, the byte is dropped and overflow is set on the next edge. This holds even if a pop occurs in the same cycle, because the full test uses pre-edge state.
- overflow:
  - Set has priority over clear_overflow when both occur in the same cycle.
  - Otherwise clear_overflow=1 clears it on the next edge.
- Pop and write in the same cycle: count is unchanged; pointers wrap modulo depth.
- eol_cnt (internal, DEPTH_LOG2+1 bits) = number of EOL_CHAR bytes currently stored.
  - +1 on a write of EOL_CHAR, −1 on a pop of EOL_CHAR.
  - Both in the same cycle leaves it unchanged.
- Eligible (the head byte may be sent):
  - modes 0 and 1: !empty.
  - mode 2: !empty and (eol_cnt>0 or full).
  - Line mode therefore releases the buffered line up to and including EOL. A full FIFO with no EOL releases bytes one at a time until it is no longer full.
- Transmit FSM:
  - IDLE: if mode != 3, eligible and tx_busy=0, then:
    - pop the head;
    - drive tx_data = transformed head and new_tx_data=1 for exactly one cycle;
    - go to HOLD.
  - IDLE in mode 3 with !empty: pop one byte per cycle, no strobe, stay in IDLE.
  - HOLD: new_tx_data=0 and tx_busy is ignored for one cycle, covering the transmitter's one-cycle busy latency. Return to IDLE.
  - Minimum spacing is therefore one strobe per 2 cycles, and a new strobe is only issued when tx_busy=0 in IDLE.
  - tx_data holds its last value outside strobes.
- Transform:
  - mode 1: bytes 8'h61..8'h7A are output minus 8'h20; all other bytes pass unchanged.
  - Modes 0 and 2: no change.
  - Stored data is never modified; the transform applies at the output only.
- Mode changes take effect on the next IDLE evaluation. A strobe in flight completes. Switching from 2 to 0 immediately makes held bytes eligible.
- Status: count, full and empty are registered and reflect post-edge state.

Test Plan:
- Reset then mode 0:
  - Stimulus: write 8'h41, 8'h42 with tx_busy=0.
  - Required: new_tx_data pulses carry 8'h41 then 8'h42, at least 2 cycles apart; count ends at 0 and empty=1.
- Mode 1:
  - Stimulus: write 8'h61, 8'h7A, 8'h5B, 8'h31.
  - Required: tx_data sequence 8'h41, 8'h5A, 8'h5B, 8'h31.
- Mode 2, DEPTH_LOG2=4:
  - Stimulus: write "hi" (8'h68, 8'h69).
  - Required: no strobe for 20 cycles and count=2.
  - Stimulus: then write 8'h0D.
  - Required: three strobes 8'h68, 8'h69, 8'h0D, and eol_cnt returns to 0.
- Backpressure:
  - Stimulus: hold tx_busy=1 and write 17 bytes (depth 16).
  - Required: full=1, count=16, overflow=1.
  - Stimulus: assert clear_overflow.
  - Required: overflow=0.
  - Stimulus: release tx_busy.
  - Required: the first 16 bytes are sent in order; the 17th byte never appears.
- Simultaneous events:
  - Stimulus: with the FIFO full, new_rx_data arrives in the same cycle as a pop; separately, new_rx_data arrives on a full FIFO in the same cycle as clear_overflow.
  - Required: count goes 16→15 and overflow=1 for the first case; overflow stays 1 for the second.
- Flush and reset:
  - Stimulus: mode 3 with 5 bytes stored.
  - Required: count decrements 5→0 over 5 cycles with no new_tx_data.
  - Stimulus: assert rst_n=0 during HOLD with 3 bytes queued.
  - Required: count=0, new_tx_data=0, and no further strobes.
